mandelbrot_scanner: RTL and testbench
=====================================

Name: mandelbrot_scanner

Overview:
Upstream sequencer for the `mandelbrot` iteration core (parameters Q, N; ports `c_real`, `c_imag`, `run`, `done`, `count[7:0]`). It walks a WIDTH x HEIGHT pixel grid in raster order and drives each point's fixed-point coordinate into the core. It handshakes `run`/`done` with the core, captures the 8-bit iteration count, and presents it with the pixel position on a valid/ready stream to the downstream sink (framebuffer or UART packer).

Parameters:
Q, 12, fractional bits of coordinates (matches core)
N, 16, total coordinate width, two's complement (matches core)
WIDTH, 64, pixels per row
HEIGHT, 48, rows per frame
XW, 8, width of px_x (must hold WIDTH-1)
YW, 8, width of px_y (must hold HEIGHT-1)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
start  in  1  begin a frame; sampled only in IDLE
x_start  in  N  real coordinate of column 0, signed Q-format
y_start  in  N  imag coordinate of row 0, signed Q-format
step_re  in  N  real increment per column, signed
step_im  in  N  imag increment per row, signed
busy  out  1  high whenever state != IDLE
frame_done  out  1  one-cycle pulse after last pixel accepted
c_real  out  N  to core
c_imag  out  N  to core
run  out  1  to core
done  in  1  from core
count  in  8  from core, valid while done=1
px_x  out  XW  column of emitted pixel
px_y  out  YW  row of emitted pixel
px_count  out  8  iteration count of emitted pixel
px_valid  out  1  output stream valid
px_ready  in  1  output stream ready

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; run, px_valid, busy and frame_done = 0; c_real, c_imag, px_x, px_y and px_count = 0; internal x/y counters = 0. This applies in any state, including mid-RUN or mid-EMIT. The core sees run=0 the cycle after reset.
- start, x_start, y_start, step_re and step_im are latched on the edge where IDLE && start. Later input changes have no effect until the next frame. start outside IDLE is ignored.
- States:
  - IDLE -> LOAD on start.
  - LOAD, 1 cycle: run=0; c_real/c_imag hold the current pixel coordinate. -> RUN.
  - RUN: run=1, coordinates stable. Stays until done=1 is sampled. On that edge it captures count into px_count, sets px_x/px_y = x/y, and goes -> EMIT. run drops to 0 on the same edge.
  - EMIT: px_valid=1; px_x, px_y and px_count are held stable until px_valid && px_ready. On the handshake edge it advances. If x==WIDTH-1 and y==HEIGHT-1 -> IDLE with frame_done=1 for the next cycle. Otherwise -> LOAD.
- done is ignored outside RUN. Run is guaranteed low for at least 2 cycles (EMIT + LOAD) between pixels, so the core rearms and a stale done is never accepted.
- Advance order is raster, x fastest:
  - If x<WIDTH-1: x+=1, c_real+=step_re.
  - Else: x=0, c_real=x_start, y+=1, c_imag+=step_im.
- Coordinate arithmetic is N-bit two's complement add, wrapping modulo 2^N with no saturation. Accumulation is used (no multiply), so pixel (x,y) has c_real = x_start + x*step_re mod 2^N.
- At frame start: c_real=x_start, c_imag=y_start.
- Per-pixel latency from entering LOAD to px_valid is core_iterations + 2 cycles, minimum.
- px_valid never drops without a handshake. px_ready may be held high permanently; the next pixel then starts LOAD on the following cycle.
- frame_done and start simultaneously: the start is accepted on the following cycle (IDLE).
- WIDTH=1 and/or HEIGHT=1 must work (row wrap on every pixel; single-pixel frame).

Test Plan:
1. WIDTH=2, HEIGHT=2, x_start=0xE000 (-2.0), y_start=0xF000 (-1.0), step_re=0x1000, step_im=0x0800, px_ready=1, stub core with done 3 cycles after run -> 4 pixels in order (0,0)(1,0)(0,1)(1,1). c_real/c_imag in RUN are E000/F000, F000/F000, E000/F800, F000/F800. One frame_done pulse, then busy=0.
2. Real core, Q=12, N=16, c=0x0030+0x0030i (1-pixel frame) -> run held until done; px_count equals core count; run low within 1 cycle of done.
3. Backpressure: px_ready=0 for 10 cycles during EMIT -> px_valid stays 1, outputs stable, run stays 0, no new LOAD; px_ready=1 -> advance next cycle.
4. rst pulsed during RUN of pixel (1,0) -> next cycle run=0, px_valid=0, busy=0. A following start restarts at (0,0) with c_real=x_start.
5. start pulsed while busy, with x_start changed -> ignored; frame continues with the originally latched values.
6. step_re=0x7000, x_start=0x7000, WIDTH=3 -> c_real sequence 7000, E000, 5000 (mod-2^16 wrap).

Source files
------------

// File: rtl/mandelbrot_scanner.sv
// Raster-order pixel sequencer for the mandelbrot core: LOAD -> RUN -> EMIT per pixel, accumulating coordinates.
// Latency LOAD to px_valid = core iterations + 2; EMIT holds px_* until px_ready, stalling the whole walk.
module mandelbrot_scanner #(
    parameter int Q      = 12,
    parameter int N      = 16,
    parameter int WIDTH  = 64,
    parameter int HEIGHT = 48,
    parameter int XW     = 8,
    parameter int YW     = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [N-1:0]  x_start,
    input  logic [N-1:0]  y_start,
    input  logic [N-1:0]  step_re,
    input  logic [N-1:0]  step_im,
    output logic          busy,
    output logic          frame_done,
    output logic [N-1:0]  c_real,
    output logic [N-1:0]  c_imag,
    output logic          run,
    input  logic          done,
    input  logic [7:0]    count,
    output logic [XW-1:0] px_x,
    output logic [YW-1:0] px_y,
    output logic [7:0]    px_count,
    output logic          px_valid,
    input  logic          px_ready
);

    if (WIDTH < 1 || HEIGHT < 1 || WIDTH > (1 << XW) || HEIGHT > (1 << YW) || Q >= N) begin : g_bad_params
        $error("mandelbrot_scanner: inconsistent parameters");
    end

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_EMIT = 2'd3;

    localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

    logic [1:0]    state_q, state_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [N-1:0]  c_real_q, c_real_d;
    logic [N-1:0]  c_imag_q, c_imag_d;
    logic [N-1:0]  x_start_q, x_start_d;
    logic [N-1:0]  step_re_q, step_re_d;
    logic [N-1:0]  step_im_q, step_im_d;
    logic [XW-1:0] px_x_q, px_x_d;
    logic [YW-1:0] px_y_q, px_y_d;
    logic [7:0]    px_count_q, px_count_d;
    logic          frame_done_q, frame_done_d;

    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        c_real_d     = c_real_q;
        c_imag_d     = c_imag_q;
        x_start_d    = x_start_q;
        step_re_d    = step_re_q;
        step_im_d    = step_im_q;
        px_x_d       = px_x_q;
        px_y_d       = px_y_q;
        px_count_d   = px_count_q;
        frame_done_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    x_start_d = x_start;
                    step_re_d = step_re;
                    step_im_d = step_im;
                    c_real_d  = x_start;
                    c_imag_d  = y_start;
                    x_d       = '0;
                    y_d       = '0;
                    state_d   = S_LOAD;
                end
            end
            S_LOAD: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                if (done) begin
                    px_count_d = count;
                    px_x_d     = x_q;
                    px_y_d     = y_q;
                    state_d    = S_EMIT;
                end
            end
            default: begin
                if (px_ready) begin
                    if (x_q == X_LAST && y_q == Y_LAST) begin
                        frame_done_d = 1'b1;
                        state_d      = S_IDLE;
                    end else if (x_q != X_LAST) begin
                        x_d      = x_q + XW'(1);
                        c_real_d = c_real_q + step_re_q;
                        state_d  = S_LOAD;
                    end else begin
                        // Row wrap restarts the real axis from the latched origin, not by subtraction.
                        x_d      = '0;
                        c_real_d = x_start_q;
                        y_d      = y_q + YW'(1);
                        c_imag_d = c_imag_q + step_im_q;
                        state_d  = S_LOAD;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            x_q          <= '0;
            y_q          <= '0;
            c_real_q     <= '0;
            c_imag_q     <= '0;
            x_start_q    <= '0;
            step_re_q    <= '0;
            step_im_q    <= '0;
            px_x_q       <= '0;
            px_y_q       <= '0;
            px_count_q   <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            c_real_q     <= c_real_d;
            c_imag_q     <= c_imag_d;
            x_start_q    <= x_start_d;
            step_re_q    <= step_re_d;
            step_im_q    <= step_im_d;
            px_x_q       <= px_x_d;
            px_y_q       <= px_y_d;
            px_count_q   <= px_count_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign busy       = (state_q != S_IDLE);
    assign run        = (state_q == S_RUN);
    assign px_valid   = (state_q == S_EMIT);
    assign frame_done = frame_done_q;
    assign c_real     = c_real_q;
    assign c_imag     = c_imag_q;
    assign px_x       = px_x_q;
    assign px_y       = px_y_q;
    assign px_count   = px_count_q;

endmodule

// File: tb/tb_mandelbrot_scanner.sv
// Directed bench: 3x2 scanner with a stub core, plus a 1x1 instance for the single-pixel frame.
module tb_mandelbrot_scanner;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, start1, px_ready, done_force;
    logic [15:0] x_start, y_start, step_re, step_im;
    logic        busy, frame_done, run, done, px_valid;
    logic [15:0] c_real, c_imag;
    logic [7:0]  count, px_x, px_y, px_count;
    int          lat;

    mandelbrot_scanner #(.Q(12), .N(16), .WIDTH(3), .HEIGHT(2), .XW(8), .YW(8)) dut (
        .clk(clk), .rst(rst), .start(start),
        .x_start(x_start), .y_start(y_start), .step_re(step_re), .step_im(step_im),
        .busy(busy), .frame_done(frame_done), .c_real(c_real), .c_imag(c_imag),
        .run(run), .done(done), .count(count),
        .px_x(px_x), .px_y(px_y), .px_count(px_count), .px_valid(px_valid), .px_ready(px_ready)
    );

    // Stub core: done after lat+1 cycles of run; count is a fixed function of c.
    logic [7:0] run_cyc;
    always @(posedge clk) run_cyc <= run ? run_cyc + 8'd1 : 8'd0;
    assign done  = (run && run_cyc == lat[7:0]) || done_force;
    assign count = c_real[15:8] ^ c_imag[15:8];

    logic        busy1, frame_done1, run1, done1, px_valid1;
    logic [15:0] c_real1, c_imag1;
    logic [7:0]  count1, px_count1;
    logic [0:0]  px_x1, px_y1;

    mandelbrot_scanner #(.Q(12), .N(16), .WIDTH(1), .HEIGHT(1), .XW(1), .YW(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1),
        .x_start(x_start), .y_start(y_start), .step_re(step_re), .step_im(step_im),
        .busy(busy1), .frame_done(frame_done1), .c_real(c_real1), .c_imag(c_imag1),
        .run(run1), .done(done1), .count(count1),
        .px_x(px_x1), .px_y(px_y1), .px_count(px_count1), .px_valid(px_valid1), .px_ready(1'b1)
    );

    logic [7:0] run_cyc1;
    always @(posedge clk) run_cyc1 <= run1 ? run_cyc1 + 8'd1 : 8'd0;
    assign done1  = run1 && run_cyc1 == 8'd2;
    assign count1 = c_real1[15:8] ^ c_imag1[15:8];

    int         n1 = 0, fd1 = 0;
    logic [7:0] cap_cnt1 = 8'h00;
    logic       cap_x1 = 1'b1, cap_y1 = 1'b1;
    always @(negedge clk) begin
        if (!rst) begin
            if (px_valid1) begin
                cap_cnt1 <= px_count1;
                cap_x1   <= px_x1[0];
                cap_y1   <= px_y1[0];
                n1       <= n1 + 1;
            end
            if (frame_done1) fd1 <= fd1 + 1;
        end
    end

    typedef struct {
        logic [7:0]  x;
        logic [7:0]  y;
        logic [15:0] cr;
        logic [15:0] ci;
        logic [7:0]  cnt;
    } pix_t;
    pix_t vec[12];

    int tests = 0, fails = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic wait_run(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (run) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_valid(output bit ok, output int rl);
        ok = 1'b0;
        rl = 0;
        for (int i = 0; i < 100; i++) begin
            if (px_valid) begin
                ok = 1'b1;
                break;
            end
            if (run) rl++;
            @(negedge clk);
        end
    endtask

    task automatic do_frame(input int base, input int n, input bit stall, input bit restart_mid);
        bit ok;
        int rl;
        for (int p = base; p < base + n; p++) begin
            if (restart_mid && p == base + 2) begin
                x_start = 16'h1234;
                step_re = 16'h0100;
                start   = 1'b1;
                @(negedge clk);
                start   = 1'b0;
            end
            wait_run(ok);
            chk("run_seen", 32'(ok), 32'd1);
            chk("c_real", 32'(c_real), 32'(vec[p].cr));
            chk("c_imag", 32'(c_imag), 32'(vec[p].ci));
            wait_valid(ok, rl);
            chk("valid_seen", 32'(ok), 32'd1);
            chk("run_len", 32'(rl), 32'(lat + 1));
            chk("run_low_emit", 32'(run), 32'd0);
            chk("px_x", 32'(px_x), 32'(vec[p].x));
            chk("px_y", 32'(px_y), 32'(vec[p].y));
            chk("px_count", 32'(px_count), 32'(vec[p].cnt));
            if (stall && p == base) begin
                done_force = 1'b1;
                repeat (10) begin
                    @(negedge clk);
                    chk("hold_valid", 32'(px_valid), 32'd1);
                    chk("hold_run", 32'(run), 32'd0);
                    chk("hold_x", 32'(px_x), 32'(vec[p].x));
                    chk("hold_cnt", 32'(px_count), 32'(vec[p].cnt));
                end
                done_force = 1'b0;
                px_ready   = 1'b1;
                @(negedge clk);
                chk("adv_valid", 32'(px_valid), 32'd0);
                chk("adv_busy", 32'(busy), 32'd1);
            end
        end
        @(negedge clk);
        chk("frame_done", 32'(frame_done), 32'd1);
        chk("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        bit ok;
        int rl;
        rst = 1'b1; start = 1'b0; start1 = 1'b0; px_ready = 1'b1; done_force = 1'b0; lat = 3;
        x_start = '0; y_start = '0; step_re = '0; step_im = '0;

        vec[0]  = '{8'd0, 8'd0, 16'hE000, 16'hF000, 8'h10};
        vec[1]  = '{8'd1, 8'd0, 16'hF000, 16'hF000, 8'h00};
        vec[2]  = '{8'd2, 8'd0, 16'h0000, 16'hF000, 8'hF0};
        vec[3]  = '{8'd0, 8'd1, 16'hE000, 16'hF800, 8'h18};
        vec[4]  = '{8'd1, 8'd1, 16'hF000, 16'hF800, 8'h08};
        vec[5]  = '{8'd2, 8'd1, 16'h0000, 16'hF800, 8'hF8};
        vec[6]  = '{8'd0, 8'd0, 16'h7000, 16'h0000, 8'h70};
        vec[7]  = '{8'd1, 8'd0, 16'hE000, 16'h0000, 8'hE0};
        vec[8]  = '{8'd2, 8'd0, 16'h5000, 16'h0000, 8'h50};
        vec[9]  = '{8'd0, 8'd1, 16'h7000, 16'h0100, 8'h71};
        vec[10] = '{8'd1, 8'd1, 16'hE000, 16'h0100, 8'hE1};
        vec[11] = '{8'd2, 8'd1, 16'h5000, 16'h0100, 8'h51};

        repeat (3) @(negedge clk);
        chk("rst_run", 32'(run), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(px_valid), 32'd0);
        chk("rst_fdone", 32'(frame_done), 32'd0);
        chk("rst_c_real", 32'(c_real), 32'd0);
        chk("rst_px", 32'({px_x, px_y, px_count}), 32'd0);
        rst = 1'b0;

        // Frame A: 3x2 from (-2,-1), with an ignored start mid-frame.
        x_start = 16'hE000; y_start = 16'hF000; step_re = 16'h1000; step_im = 16'h0800;
        start = 1'b1; start1 = 1'b1;
        @(negedge clk);
        start = 1'b0; start1 = 1'b0;
        chk("load_busy", 32'(busy), 32'd1);
        chk("load_run", 32'(run), 32'd0);
        do_frame(0, 6, 1'b0, 1'b1);

        chk("one_px_n", 32'(n1), 32'd1);
        chk("one_px_xy", 32'({cap_x1, cap_y1}), 32'd0);
        chk("one_px_cnt", 32'(cap_cnt1), 32'h10);
        chk("one_px_fd", 32'(fd1), 32'd1);
        chk("one_px_busy", 32'(busy1), 32'd0);

        // Frame B: wrapping accumulation, backpressure on the first pixel, slower core.
        x_start = 16'h7000; y_start = 16'h0000; step_re = 16'h7000; step_im = 16'h0100;
        lat = 5; px_ready = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        do_frame(6, 6, 1'b1, 1'b0);

        // Start in the frame_done cycle is taken; then reset lands during RUN of (1,0).
        x_start = 16'hE000; y_start = 16'hF000; step_re = 16'h1000; step_im = 16'h0800;
        lat = 3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_on_fdone", 32'(busy), 32'd1);
        wait_run(ok);
        wait_valid(ok, rl);
        wait_run(ok);
        chk("mid_run_seen", 32'(ok), 32'd1);
        chk("mid_c_real", 32'(c_real), 32'hF000);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mrst_run", 32'(run), 32'd0);
        chk("mrst_valid", 32'(px_valid), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_c_real", 32'(c_real), 32'd0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        do_frame(0, 6, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
